// File: rtl/hit_judge_if.sv
// Lane/judgement signal bundle between the game core and hit_judge.
// The master side drives game state, buttons and zone levels; the slave returns pulses.
interface hit_judge_if #(
  parameter int unsigned LANES      = 4,
  parameter int unsigned STATE_BITS = 1
);
  logic [STATE_BITS:0] state;
  logic [LANES-1:0]    btn;
  logic [LANES-1:0]    laneInZone;
  logic                correctHit;
  logic                incorrectHit;
  logic                eventDropped;

  modport master (
    output state, btn, laneInZone,
    input  correctHit, incorrectHit, eventDropped
  );

  modport slave (
    input  state, btn, laneInZone,
    output correctHit, incorrectHit, eventDropped
  );
endinterface

// File: rtl/hit_judge.sv
// Debounces lane buttons, judges presses against arrows in the hit zone and serialises
// the resulting correct/incorrect judgements as single-cycle pulses separated by a gap.
module hit_judge #(
  parameter int unsigned         STATE_BITS      = 1,
  parameter logic [STATE_BITS:0] STATE_RESET     = (STATE_BITS+1)'(0),
  parameter logic [STATE_BITS:0] STATE_GAME      = (STATE_BITS+1)'(1),
  parameter int unsigned         LANES           = 4,
  parameter int unsigned         DEBOUNCE_CYCLES = 250000,
  parameter int unsigned         PEND_MAX        = 7
) (
  input logic        clk,
  input logic        rst,
  hit_judge_if.slave bus
);

  localparam int unsigned CntW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

  typedef enum logic [1:0] {LnEmpty, LnArmed, LnSpent} lane_st_e;
  typedef enum logic [1:0] {EmIdle, EmPulse, EmGap} emit_st_e;

  logic [LANES-1:0] r_sync1, r_sync2, r_db, r_db_prev;
  logic [CntW-1:0]  r_db_cnt [LANES];
  lane_st_e         r_lane [LANES];
  lane_st_e         w_lane_next [LANES];
  emit_st_e         r_em, w_em_next;
  logic [2:0]       r_pend_c, r_pend_i, w_pend_c_next, w_pend_i_next;
  logic             r_dropped, r_correct, r_incorrect;

  logic [LANES-1:0] w_press, w_ev_c, w_ev_i;
  logic [15:0]      w_n_c, w_n_i, w_sum_c, w_sum_i;
  logic             w_take_c, w_take_i, w_drop, w_game, w_st_reset;

  assign w_game     = (bus.state == STATE_GAME);
  assign w_st_reset = (bus.state == STATE_RESET);
  assign w_press    = r_db & ~r_db_prev;

  // Debouncers keep running in every game state; only rst clears them.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1   <= '0;
      r_sync2   <= '0;
      r_db      <= '0;
      r_db_prev <= '0;
      for (int i = 0; i < int'(LANES); i++) r_db_cnt[i] <= '0;
    end else begin
      r_sync1   <= bus.btn;
      r_sync2   <= r_sync1;
      r_db_prev <= r_db;
      for (int i = 0; i < int'(LANES); i++) begin
        if (r_sync2[i] != r_db[i]) begin
          if (r_db_cnt[i] == CntW'(DEBOUNCE_CYCLES - 1)) begin
            r_db[i]     <= ~r_db[i];
            r_db_cnt[i] <= '0;
          end else begin
            r_db_cnt[i] <= r_db_cnt[i] + 1'b1;
          end
        end else begin
          r_db_cnt[i] <= '0;
        end
      end
    end
  end

  always_comb begin
    w_ev_c = '0;
    w_ev_i = '0;
    w_n_c  = '0;
    w_n_i  = '0;
    for (int i = 0; i < int'(LANES); i++) begin
      w_lane_next[i] = r_lane[i];
      if (w_game) begin
        unique case (r_lane[i])
          LnEmpty: begin
            if (w_press[i])             w_ev_i[i] = 1'b1;
            else if (bus.laneInZone[i]) w_lane_next[i] = LnArmed;
          end
          LnArmed: begin
            // A press in the same cycle the arrow leaves still counts as a hit.
            if (w_press[i]) begin
              w_ev_c[i]      = 1'b1;
              w_lane_next[i] = bus.laneInZone[i] ? LnSpent : LnEmpty;
            end else if (!bus.laneInZone[i]) begin
              w_ev_i[i]      = 1'b1;
              w_lane_next[i] = LnEmpty;
            end
          end
          LnSpent: begin
            if (w_press[i])              w_ev_i[i] = 1'b1;
            else if (!bus.laneInZone[i]) w_lane_next[i] = LnEmpty;
          end
          default: w_lane_next[i] = LnEmpty;
        endcase
      end else begin
        w_lane_next[i] = LnEmpty;
      end
      w_n_c = w_n_c + 16'(w_ev_c[i]);
      w_n_i = w_n_i + 16'(w_ev_i[i]);
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < int'(LANES); i++) begin
      if (rst) r_lane[i] <= LnEmpty;
      else     r_lane[i] <= w_lane_next[i];
    end
  end

  // Emitter: incorrect judgements drain first; pause lets a PULSE/GAP finish.
  always_comb begin
    w_em_next = r_em;
    w_take_c  = 1'b0;
    w_take_i  = 1'b0;
    unique case (r_em)
      EmIdle, EmGap: begin
        w_em_next = EmIdle;
        if (w_game && (r_pend_i != '0 || r_pend_c != '0)) begin
          w_em_next = EmPulse;
          if (r_pend_i != '0) w_take_i = 1'b1;
          else                w_take_c = 1'b1;
        end
      end
      EmPulse: w_em_next = EmGap;
      default: w_em_next = EmIdle;
    endcase
    if (w_st_reset) begin
      w_em_next = EmIdle;
      w_take_c  = 1'b0;
      w_take_i  = 1'b0;
    end
  end

  always_comb begin
    w_drop  = 1'b0;
    w_sum_c = 16'(r_pend_c) + w_n_c - 16'(w_take_c);
    w_sum_i = 16'(r_pend_i) + w_n_i - 16'(w_take_i);
    if (w_sum_c > 16'(PEND_MAX)) begin
      w_pend_c_next = 3'(PEND_MAX);
      w_drop        = 1'b1;
    end else begin
      w_pend_c_next = w_sum_c[2:0];
    end
    if (w_sum_i > 16'(PEND_MAX)) begin
      w_pend_i_next = 3'(PEND_MAX);
      w_drop        = 1'b1;
    end else begin
      w_pend_i_next = w_sum_i[2:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst || w_st_reset) begin
      r_pend_c  <= '0;
      r_pend_i  <= '0;
      r_dropped <= 1'b0;
    end else begin
      r_pend_c  <= w_pend_c_next;
      r_pend_i  <= w_pend_i_next;
      r_dropped <= r_dropped | w_drop;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_em        <= EmIdle;
      r_correct   <= 1'b0;
      r_incorrect <= 1'b0;
    end else begin
      r_em        <= w_em_next;
      r_correct   <= w_take_c;
      r_incorrect <= w_take_i;
    end
  end

  assign bus.correctHit   = r_correct;
  assign bus.incorrectHit = r_incorrect;
  assign bus.eventDropped = r_dropped;

endmodule

// File: tb/tb_hit_judge.sv
// Scoreboard bench for hit_judge: expected pulses (kind and cycle) are queued when
// stimulus is applied and checked off as the DUT emits them.
module tb_hit_judge;
  localparam int unsigned SB    = 1;
  localparam int unsigned LANES = 4;
  localparam logic [1:0] StReset = 2'd0;
  localparam logic [1:0] StGame  = 2'd1;
  localparam logic [1:0] StPause = 2'd2;

  typedef struct {
    bit          is_c;
    int unsigned cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  int unsigned cyc = 0;
  int unsigned n_checks = 0;
  int unsigned n_fail = 0;
  exp_t        sb_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  hit_judge_if #(.LANES(LANES), .STATE_BITS(SB)) bus ();

  hit_judge #(
    .STATE_BITS     (SB),
    .STATE_RESET    (StReset),
    .STATE_GAME     (StGame),
    .LANES          (LANES),
    .DEBOUNCE_CYCLES(4),
    .PEND_MAX       (7)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  task automatic check(input string tag, input int unsigned obs, input int unsigned exp);
    n_checks++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic push(input bit is_c, input int unsigned c);
    exp_t e;
    e.is_c = is_c;
    e.cyc  = c;
    sb_q.push_back(e);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (cyc >= 2) begin
      check("both_high", 32'(bus.correctHit & bus.incorrectHit), 0);
      if (bus.correctHit || bus.incorrectHit) begin
        if (sb_q.size() == 0) begin
          check("unexpected_pulse", {30'd0, bus.correctHit, bus.incorrectHit}, 0);
        end else begin
          e = sb_q.pop_front();
          check("pulse_kind_is_c", 32'(bus.correctHit), 32'(e.is_c));
          check("pulse_cycle", cyc, e.cyc);
        end
      end
    end
  end

  initial begin
    int unsigned n;
    int unsigned m;
    int unsigned e;
    rst            = 1'b1;
    bus.state      = StGame;
    bus.btn        = '0;
    bus.laneInZone = '0;
    tick(3);
    check("rst_correct", 32'(bus.correctHit), 0);
    check("rst_incorrect", 32'(bus.incorrectHit), 0);
    check("rst_dropped", 32'(bus.eventDropped), 0);
    rst = 1'b0;
    tick(2);

    // Armed lane 0, press and hold: one correct pulse after edge D+4.
    bus.laneInZone = 4'b0001;
    tick(2);
    n = cyc;
    bus.btn = 4'b0001;
    push(1'b1, n + 8);
    tick(12);
    bus.laneInZone = '0;  // lane should be SPENT, so leaving the zone is silent
    tick(2);
    bus.btn = '0;
    tick(10);

    // Press with no arrow, then a bouncing button that never settles long enough.
    n = cyc;
    bus.btn = 4'b0100;
    push(1'b0, n + 8);
    tick(12);
    bus.btn = '0;
    tick(10);
    for (int k = 0; k < 5; k++) begin
      bus.btn[3] = (k % 2 == 0);
      tick(2);
    end
    bus.btn[3] = 1'b0;
    tick(15);

    // Miss on lane 1.
    bus.laneInZone[1] = 1'b1;
    tick(5);
    n = cyc;
    bus.laneInZone[1] = 1'b0;
    push(1'b0, n + 2);
    tick(6);

    // Lanes 0,1 armed, all four pressed together: I,0,I,0,C,0,C.
    bus.laneInZone = 4'b0011;
    tick(2);
    n = cyc;
    bus.btn = 4'hF;
    push(1'b0, n + 8);
    push(1'b0, n + 10);
    push(1'b1, n + 12);
    push(1'b1, n + 14);
    tick(20);
    bus.laneInZone = '0;
    tick(2);
    bus.btn = '0;
    tick(12);

    // Overflow: all lanes miss at e, e+2, e+4; 9 pulses survive.
    m = cyc;
    e = m + 2;
    for (int j = 0; j < 9; j++) push(1'b0, e + 1 + 2 * j);
    bus.laneInZone = 4'hF;
    tick(1);
    bus.laneInZone = 4'h0;
    tick(1);
    bus.laneInZone = 4'hF;
    check("drop_e", 32'(bus.eventDropped), 0);
    tick(1);
    bus.laneInZone = 4'h0;
    tick(1);
    bus.laneInZone = 4'hF;
    tick(1);
    bus.laneInZone = 4'h0;
    check("drop_e3", 32'(bus.eventDropped), 0);
    tick(1);
    check("drop_e4", 32'(bus.eventDropped), 1);
    tick(20);
    check("drop_sticky", 32'(bus.eventDropped), 1);
    bus.state = StReset;
    tick(2);
    check("streset_drop", 32'(bus.eventDropped), 0);
    check("streset_out", {31'd0, bus.correctHit | bus.incorrectHit}, 0);
    bus.state = StGame;
    tick(2);

    // Pause with three pending correct events, resume, then rst during second pulse.
    bus.laneInZone = 4'b0111;
    tick(2);
    n = cyc;
    bus.btn = 4'b0111;
    tick(7);
    bus.state = StPause;
    tick(1);
    bus.laneInZone = '0;
    for (int k = 0; k < 8; k++) begin
      check("pause_quiet", {31'd0, bus.correctHit | bus.incorrectHit}, 0);
      tick(1);
    end
    bus.btn = '0;
    bus.state = StGame;
    n = cyc;
    push(1'b1, n + 1);
    push(1'b1, n + 3);
    tick(3);
    check("second_pulse", 32'(bus.correctHit), 1);
    rst = 1'b1;
    tick(1);
    check("rst_mid_c", 32'(bus.correctHit), 0);
    check("rst_mid_i", 32'(bus.incorrectHit), 0);
    check("rst_mid_drop", 32'(bus.eventDropped), 0);
    tick(3);
    rst = 1'b0;
    tick(15);

    check("sb_empty", sb_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/hit_judge.md
# hit_judge

Judges player button presses against arrows in the hit zone and emits the `correctHit` / `incorrectHit` pulse stream consumed by the score block. It sits between the raw lane buttons / arrow scroller and the score logic. It debounces buttons, runs a per-lane arm/consume FSM, and queues simultaneous judgements. It then serialises them as single-cycle pulses separated by at least one low cycle, so every event is seen as a distinct rising edge downstream.

## Interface
Parameters:
- `STATE_BITS`, `STATE_RESET`, `STATE_GAME`: shared game-state definitions from `ddr_definitions.v`.
- `LANES`, default 4: number of arrow lanes.
- `DEBOUNCE_CYCLES`, default 250000: number of stable synchronised samples required to accept a button change (D below).
- `PEND_MAX`, default 7: saturation value of each pending counter (3 bits).

Ports:
- `clk`, input, 1: the single clock; all logic is on its rising edge.
- `rst`, input, 1: synchronous, active-high reset.
- `state`, input, [STATE_BITS:0]: current game state.
- `btn`, input, [LANES-1:0]: raw, asynchronous, bouncing lane buttons.
- `laneInZone`, input, [LANES-1:0]: per-lane level from the scroller, synchronous to `clk`; goes low for at least 1 cycle between arrows.
- `correctHit`, output, 1: registered pulse, one per correct judgement.
- `incorrectHit`, output, 1: registered pulse, one per wrong press or missed arrow.
- `eventDropped`, output, 1: sticky flag, set when a judgement is lost to counter saturation.

## Operation
- **Debounce**
  - Each button passes through a 2-flop synchroniser.
  - A per-lane counter counts consecutive cycles where the synchronised value differs from the debounced value `db`; any equal cycle clears the counter.
  - After D differing samples, `db` toggles and the counter clears.
  - `press[i] = db[i] & ~db_prev[i]`. Releases generate nothing.
- **Lane FSM (per lane): EMPTY, ARMED, SPENT**
  - EMPTY, `laneInZone` = 1 → ARMED.
  - ARMED, press → correct event. Next state is SPENT, or EMPTY if `laneInZone` = 0 in the same cycle (press wins over the miss).
  - ARMED, `laneInZone` = 0 with no press → incorrect event (miss), next state EMPTY.
  - SPENT, `laneInZone` = 0 → EMPTY.
  - Press in EMPTY or SPENT → incorrect event; the state is unchanged.
- **Pending counters**
  - Two 3-bit counters, `pendC` and `pendI`.
  - Each edge: counter += number of same-cycle events of that kind (0..LANES), minus 1 if the emitter takes one this edge.
  - The result saturates at PEND_MAX; any clipped event sets `eventDropped`.
- **Emitter FSM: IDLE, PULSE, GAP**
  - IDLE with any pending count → PULSE. `pendI` has priority over `pendC`.
  - Entering PULSE decrements the selected counter; the matching output is high for exactly that cycle.
  - PULSE → GAP, with both outputs low.
  - GAP → PULSE if anything is pending, else → IDLE.
  - Maximum rate is one event per 2 cycles; `correctHit` and `incorrectHit` are never high together.
- **Game state**
  - `state == STATE_GAME`: normal judging.
  - `state == STATE_RESET`:
    - lanes are forced to EMPTY;
    - pending counters and `eventDropped` are cleared;
    - the emitter goes to IDLE and outputs go low at the next edge;
    - the debouncers keep running, so a held button produces no press on return to game.
  - Any other state (pause):
    - no judgements; lanes are forced to EMPTY; presses are discarded;
    - pending counts are held;
    - the emitter finishes any PULSE/GAP in progress, then holds IDLE;
    - draining resumes on return to STATE_GAME.
- **`rst`**: all of the above cleared, plus synchroniser, debouncer and `db` cleared to 0.

## Timing
- Reset values: `correctHit` = 0, `incorrectHit` = 0, `eventDropped` = 0; all lanes EMPTY, pending 0, emitter IDLE.
- **Press latency.** Take edge 1 as the first edge that samples `btn` = 1 stably. Then:
  - `db` rises at edge D+2;
  - the event is counted at edge D+3;
  - the output goes high after edge D+4 and lasts 1 cycle.
- **Miss latency.** If `laneInZone` falls at edge k, the counter increments at edge k+1 and `incorrectHit` is high after edge k+2.
- A `rst` or STATE_RESET asserted mid-pulse forces the outputs low from the next edge.

## Test plan
1. D=4. Lane 0 ARMED, press and hold lane 0 → `correctHit` high for exactly one cycle after edge 8; `incorrectHit` stays 0; lane 0 goes to SPENT.
2. Press lane 2 with `laneInZone` = 0 → one `incorrectHit` pulse at the same latency; bouncing `btn` (toggling every 2 cycles for 10 cycles) produces no event.
3. `laneInZone[1]` high for 5 cycles then low with no press → one `incorrectHit` pulse 2 edges after the fall.
4. Lanes 0 and 1 ARMED, all four lanes pressed in the same cycle → output sequence I,0,I,0,C,0,C: two `incorrectHit` pulses, then two `correctHit` pulses, each 1 cycle with 1-cycle gaps.
5. Overflow: all four lanes miss at edges e, e+2 and e+4 (12 events) → exactly 9 `incorrectHit` pulses in total; `eventDropped` = 1 from edge e+4 until reset.
6. Pause with `pendC` = 3: outputs stay low and counts are held; returning to STATE_GAME gives 3 pulses. Asserting `rst` during the second pulse gives all outputs 0 at the next edge and no further pulses.
